mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified instruction/data memory port between the fetch stage (read-only) and the memory stage (load/store) of the five-stage pipeline. It issues one transaction at a time through a three-state FSM and routes the response back to the requester that owns it. Data accesses take priority, with a starvation limit that guarantees fetch progress. Per-stage stall outputs go to the hazard unit, and flushed fetches are killed without disturbing the memory protocol.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: data width; byte-enable width is `DATA_WIDTH/8`.
- `STARVE_LIMIT`, 4: number of consecutive data grants allowed while fetch waits (≥1).

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch read request; held until `if_valid`.
- `if_addr`  in  ADDR_WIDTH  fetch address.
- `if_flush`  in  1  kills any fetch owned or pending in the arbiter.
- `if_rdata`  out  DATA_WIDTH  fetch read data; valid only with `if_valid`.
- `if_valid`  out  1  one-cycle fetch completion.
- `dm_req`  in  1  data request; held until `dm_valid`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_be`  in  DATA_WIDTH/8  store byte enables.
- `dm_addr`  in  ADDR_WIDTH  data address.
- `dm_wdata`  in  DATA_WIDTH  store data.
- `dm_rdata`  out  DATA_WIDTH  load data; valid only with `dm_valid`.
- `dm_valid`  out  1  one-cycle data completion (loads and stores).
- `stall_F`  out  1  `if_req && !if_valid`.
- `stall_M`  out  1  `dm_req && !dm_valid`.
- `mem_req`  out  1  memory request; held with stable fields until `mem_gnt`.
- `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  (as `dm_*`)  latched request fields. Fetch uses `we=0` and `be` all ones.
- `mem_gnt`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  response or write acknowledgement.
- `mem_rdata`  in  DATA_WIDTH  read data with `mem_rvalid`.

## Operation
FSM states: IDLE, WAIT_GNT, WAIT_RSP.

**IDLE**
- Evaluate requests. Fetch is eligible only if `if_req && !if_flush`.
- If both requesters are eligible, data wins unless `starve_cnt == STARVE_LIMIT`; in that case fetch wins.
- The winner's fields are registered into `mem_*`, `owner` is set to IF or DM, `killed` is cleared, and the FSM moves to WAIT_GNT.
- With no eligible requester, the FSM stays in IDLE.

**Starvation counter**
- Increments on each data grant made while `if_req` is high, saturating at `STARVE_LIMIT`.
- Clears on any fetch grant.
- Clears on a data grant made while `if_req` is low.

**WAIT_GNT**
- `mem_req = 1` with all `mem_*` fields stable.
- On `mem_gnt`, move to WAIT_RSP.

**WAIT_RSP**
- `mem_req = 0`.
- On `mem_rvalid`, move to IDLE. In the same cycle, `if_valid` or `dm_valid` is driven combinationally for the owner, with `*_rdata = mem_rdata`.
- If `owner == IF` and `killed` is set, `if_valid` is suppressed.

**Flush**
- `if_flush` while `owner == IF` in WAIT_GNT or WAIT_RSP sets `killed`.
- The transaction still completes on the memory side; `mem_req` is never retracted.
- `if_flush` has no effect on data transactions.

**Other rules**
- `mem_rvalid` is ignored outside WAIT_RSP.
- Each requester deasserts its request or presents a new one on the edge after its `*_valid`. IDLE samples the new request on that cycle.

## Timing
**Reset values:** state IDLE; `mem_req`, `mem_we` = 0; `mem_be`, `mem_addr`, `mem_wdata` = 0; `owner` = IF; `killed` = 0; `starve_cnt` = 0; `if_valid`, `dm_valid` = 0.

**Reset mid-transaction:** the transaction is abandoned and any later `mem_rvalid` is ignored. The memory is reset by the same `rst`.

**Minimum latency:** request sampled in IDLE at cycle 0, `mem_req` at cycle 1. With `mem_gnt` at cycle 1 and `mem_rvalid` at cycle 2, `*_valid` is at cycle 2. The next request can be sampled at cycle 3.

**Throughput:** at most one transaction per 3 cycles.

**Simultaneous events:**
- `if_flush` together with `mem_rvalid` for a fetch: `if_valid` is suppressed.
- `if_flush` in IDLE together with `dm_req`: data is granted.

**Stall outputs:** `stall_F` and `stall_M` are combinational, so they drop in the same cycle as `*_valid`.

## Test plan
- **Single load:** `dm_req=1`, `dm_we=0`, `dm_addr=0x100`; memory gives `gnt` in cycle 1 and `rvalid` with `rdata=0xDEADBEEF` in cycle 2 → `mem_addr=0x100` in cycle 1; `dm_valid=1` and `dm_rdata=0xDEADBEEF` in cycle 2 only; `stall_M` high in cycles 0–1.
- **Priority:** `if_req` and `dm_req` both held; memory gives zero-wait `gnt` and `rvalid` → grant order DM, DM, DM, DM, IF with `STARVE_LIMIT=4`; `starve_cnt` reaches 4 and then clears.
- **Store:** `dm_we=1`, `dm_be=4'b0011`, `dm_wdata=0x12345678` → `mem_we=1`, `mem_be=0011`, `mem_wdata=0x12345678`; `dm_valid` pulses on the write acknowledgement `mem_rvalid`.
- **Killed fetch:** fetch `0x40` granted, then `if_flush` in WAIT_RSP; `rvalid` arrives 3 cycles later → no `if_valid`. The next fetch `0x80` is issued only after IDLE is reached.
- **Back-pressure:** `mem_gnt` held low for 5 cycles → `mem_req` stays high with `mem_addr` stable for all 5 cycles; `mem_rvalid` pulsed spuriously in WAIT_GNT → ignored.
- **Reset:** `rst` asserted in WAIT_RSP → next cycle state is IDLE with all outputs at reset values; a `mem_rvalid` on the following cycle produces no `*_valid`.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: shared memory port bus between the arbiter (master) and the unified memory (slave)
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data stages with data priority and fetch anti-starvation
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_flush,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_valid,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [DATA_WIDTH/8-1:0] dm_be,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    dm_valid,
    output logic                    stall_F,
    output logic                    stall_M,
    mem_port_arbiter_if.master      mem
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    state_t        state, state_n;
    owner_t        owner;
    logic          killed;
    logic [CW-1:0] starve_cnt;
    logic          if_elig, pick_if, grant, rsp;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_comb begin
        if_elig  = if_req && !if_flush;
        pick_if  = if_elig && (!dm_req || starve_cnt == LIM);
        grant    = state == IDLE && (if_elig || dm_req);
        rsp      = state == WAIT_RSP && mem.rvalid;
        state_n  = grant ? WAIT_GNT :
                   (state == WAIT_GNT && mem.gnt) ? WAIT_RSP :
                   rsp ? IDLE : state;
        mem.req  = state == WAIT_GNT;
        // a flush arriving with the response must still hide it
        if_valid = rsp && owner == OWN_IF && !killed && !if_flush;
        dm_valid = rsp && owner == OWN_DM;
        if_rdata = mem.rdata;
        dm_rdata = mem.rdata;
        stall_F  = if_req && !if_valid;
        stall_M  = dm_req && !dm_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem.we     <= 1'b0;
            mem.be     <= '0;
            mem.addr   <= '0;
            mem.wdata  <= '0;
            owner      <= OWN_IF;
            killed     <= 1'b0;
            starve_cnt <= '0;
        end else if (grant) begin
            mem.we     <= !pick_if && dm_we;
            mem.be     <= pick_if ? '1 : dm_be;
            mem.addr   <= pick_if ? if_addr : dm_addr;
            mem.wdata  <= pick_if ? '0 : dm_wdata;
            owner      <= pick_if ? OWN_IF : OWN_DM;
            killed     <= 1'b0;
            starve_cnt <= (pick_if || !if_req) ? '0 :
                          (starve_cnt == LIM) ? starve_cnt : starve_cnt + 1'b1;
        end else if (state != IDLE && owner == OWN_IF && if_flush) begin
            killed     <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario tests for mem_port_arbiter with hand-computed expectations
module tb_mem_port_arbiter;
    logic        clk = 0;
    logic        rst = 1;
    logic        if_req = 0, if_flush = 0, dm_req = 0, dm_we = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
    logic [3:0]  dm_be = 0;
    logic [31:0] if_rdata, dm_rdata;
    logic        if_valid, dm_valid, stall_F, stall_M;
    logic        gnt_d = 0, rvalid_d = 0, auto = 0, pend;
    logic [31:0] rdata_d = 0;
    int          tests = 0, fails = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m ();

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .stall_F(stall_F), .stall_M(stall_M), .mem(m.master)
    );

    always #5 clk = ~clk;

    // zero-wait memory used when auto is set: grant immediately, respond next cycle
    always_ff @(posedge clk) pend <= !rst && auto && m.req && m.gnt;
    assign m.gnt    = auto ? m.req : gnt_d;
    assign m.rvalid = auto ? pend : rvalid_d;
    assign m.rdata  = auto ? 32'hA5A5_0000 : rdata_d;

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        cyc(); cyc();
        tests++; if (m.req !== 1'b0) begin fails++; $display("FAIL reset mem_req got %b want 0", m.req); end
        tests++; if (m.we !== 1'b0 || m.be !== 4'h0) begin fails++; $display("FAIL reset we/be got %b/%h want 0/0", m.we, m.be); end
        tests++; if (m.addr !== 32'h0 || m.wdata !== 32'h0) begin fails++; $display("FAIL reset addr/wdata got %h/%h want 0/0", m.addr, m.wdata); end
        tests++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin fails++; $display("FAIL reset valids got %b/%b want 0/0", if_valid, dm_valid); end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_load();
        @(negedge clk); dm_req = 1; dm_we = 0; dm_addr = 32'h100; #1;
        tests++; if (stall_M !== 1'b1 || m.req !== 1'b0) begin fails++; $display("FAIL load c0 stall_M/req got %b/%b want 1/0", stall_M, m.req); end
        @(negedge clk); gnt_d = 1; #1;
        tests++; if (m.req !== 1'b1 || m.addr !== 32'h100) begin fails++; $display("FAIL load c1 req/addr got %b/%h want 1/100", m.req, m.addr); end
        tests++; if (stall_M !== 1'b1 || dm_valid !== 1'b0) begin fails++; $display("FAIL load c1 stall_M/dm_valid got %b/%b want 1/0", stall_M, dm_valid); end
        @(negedge clk); gnt_d = 0; rvalid_d = 1; rdata_d = 32'hDEADBEEF; #1;
        tests++; if (dm_valid !== 1'b1 || dm_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL load c2 dm_valid/rdata got %b/%h want 1/deadbeef", dm_valid, dm_rdata); end
        tests++; if (stall_M !== 1'b0 || m.req !== 1'b0 || if_valid !== 1'b0) begin fails++; $display("FAIL load c2 stall_M/req/if_valid got %b/%b/%b want 0/0/0", stall_M, m.req, if_valid); end
        @(negedge clk); rvalid_d = 0; dm_req = 0; #1;
        tests++; if (dm_valid !== 1'b0 || m.req !== 1'b0) begin fails++; $display("FAIL load c3 dm_valid/req got %b/%b want 0/0", dm_valid, m.req); end
    endtask

    task automatic test_store();
        @(negedge clk); dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h204; dm_wdata = 32'h12345678;
        @(negedge clk); gnt_d = 1; #1;
        tests++; if (m.we !== 1'b1 || m.be !== 4'b0011 || m.wdata !== 32'h12345678) begin fails++; $display("FAIL store fields got we=%b be=%b wdata=%h want 1/0011/12345678", m.we, m.be, m.wdata); end
        @(negedge clk); gnt_d = 0; rvalid_d = 1; rdata_d = 32'h0; #1;
        tests++; if (dm_valid !== 1'b1) begin fails++; $display("FAIL store ack dm_valid got %b want 1", dm_valid); end
        @(negedge clk); rvalid_d = 0; dm_req = 0; dm_we = 0; dm_be = 0; #1;
        tests++; if (dm_valid !== 1'b0) begin fails++; $display("FAIL store after ack dm_valid got %b want 0", dm_valid); end
    endtask

    task automatic test_priority();
        logic [31:0] exp_addr;
        bit ok;
        @(negedge clk); auto = 1; if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        for (int g = 0; g < 5; g++) begin
            exp_addr = (g < 4) ? 32'h200 : 32'h40;
            ok = 0;
            for (int i = 0; i < 8 && !ok; i++) begin
                cyc();
                ok = m.req;
            end
            tests++;
            if (!ok) begin
                fails++; $display("FAIL priority grant %0d timeout got req=0 want 1", g);
            end else begin
                if (m.addr !== exp_addr) begin fails++; $display("FAIL priority grant %0d addr got %h want %h", g, m.addr, exp_addr); end
                cyc();
                tests++;
                if ((g < 4 && dm_valid !== 1'b1) || (g == 4 && if_valid !== 1'b1)) begin fails++; $display("FAIL priority grant %0d valid got if=%b dm=%b", g, if_valid, dm_valid); end
            end
        end
        @(negedge clk); if_req = 0; dm_req = 0;
        cyc(); cyc(); auto = 0;
    endtask

    task automatic test_killed_fetch();
        @(negedge clk); if_req = 1; if_addr = 32'h40;
        @(negedge clk); gnt_d = 1; #1;
        tests++; if (m.req !== 1'b1 || m.addr !== 32'h40 || m.be !== 4'hF || m.we !== 1'b0) begin fails++; $display("FAIL kill issue got req=%b addr=%h be=%h we=%b", m.req, m.addr, m.be, m.we); end
        @(negedge clk); gnt_d = 0; if_flush = 1; #1;
        tests++; if (if_valid !== 1'b0 || m.req !== 1'b0) begin fails++; $display("FAIL kill flush cycle if_valid/req got %b/%b want 0/0", if_valid, m.req); end
        @(negedge clk); if_flush = 0; if_addr = 32'h80; #1;
        tests++; if (m.req !== 1'b0) begin fails++; $display("FAIL kill waiting req got %b want 0", m.req); end
        @(negedge clk);
        @(negedge clk); rvalid_d = 1; rdata_d = 32'h11111111; #1;
        tests++; if (if_valid !== 1'b0 || stall_F !== 1'b1) begin fails++; $display("FAIL kill rsp if_valid/stall_F got %b/%b want 0/1", if_valid, stall_F); end
        @(negedge clk); rvalid_d = 0; #1;
        tests++; if (m.req !== 1'b0) begin fails++; $display("FAIL kill idle req got %b want 0", m.req); end
        @(negedge clk); gnt_d = 1; #1;
        tests++; if (m.req !== 1'b1 || m.addr !== 32'h80) begin fails++; $display("FAIL kill next fetch req/addr got %b/%h want 1/80", m.req, m.addr); end
        @(negedge clk); gnt_d = 0; rvalid_d = 1; rdata_d = 32'hCAFEF00D; #1;
        tests++; if (if_valid !== 1'b1 || if_rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL kill next fetch valid/rdata got %b/%h want 1/cafef00d", if_valid, if_rdata); end
        @(negedge clk); rvalid_d = 0; if_req = 0;
    endtask

    task automatic test_flush_rsp();
        @(negedge clk); if_req = 1; if_addr = 32'h90;
        @(negedge clk); gnt_d = 1;
        @(negedge clk); gnt_d = 0; rvalid_d = 1; if_flush = 1; #1;
        tests++; if (if_valid !== 1'b0 || stall_F !== 1'b1) begin fails++; $display("FAIL flush+rvalid if_valid/stall_F got %b/%b want 0/1", if_valid, stall_F); end
        @(negedge clk); rvalid_d = 0; if_flush = 0; if_req = 0; #1;
        tests++; if (m.req !== 1'b0) begin fails++; $display("FAIL flush+rvalid idle req got %b want 0", m.req); end
    endtask

    task automatic test_backpressure();
        @(negedge clk); dm_req = 1; dm_we = 0; dm_addr = 32'h300;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); rvalid_d = (i == 2); #1;
            tests++; if (m.req !== 1'b1 || m.addr !== 32'h300 || dm_valid !== 1'b0) begin fails++; $display("FAIL backpressure cycle %0d req/addr/dm_valid got %b/%h/%b want 1/300/0", i, m.req, m.addr, dm_valid); end
        end
        @(negedge clk); rvalid_d = 0; gnt_d = 1; #1;
        tests++; if (m.req !== 1'b1) begin fails++; $display("FAIL backpressure grant req got %b want 1", m.req); end
        @(negedge clk); gnt_d = 0; rvalid_d = 1; rdata_d = 32'h0BADF00D; #1;
        tests++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h0BADF00D) begin fails++; $display("FAIL backpressure rsp got %b/%h want 1/0badf00d", dm_valid, dm_rdata); end
        @(negedge clk); rvalid_d = 0; dm_req = 0;
    endtask

    task automatic test_flush_idle();
        @(negedge clk); if_req = 1; if_flush = 1; if_addr = 32'hA0; dm_req = 1; dm_addr = 32'h400;
        @(negedge clk); if_flush = 0; gnt_d = 1; #1;
        tests++; if (m.req !== 1'b1 || m.addr !== 32'h400) begin fails++; $display("FAIL flush idle grant req/addr got %b/%h want 1/400", m.req, m.addr); end
        @(negedge clk); gnt_d = 0; rvalid_d = 1; #1;
        tests++; if (dm_valid !== 1'b1 || if_valid !== 1'b0) begin fails++; $display("FAIL flush idle rsp dm/if got %b/%b want 1/0", dm_valid, if_valid); end
        @(negedge clk); rvalid_d = 0; dm_req = 0; if_req = 0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk); dm_req = 1; dm_we = 1; dm_be = 4'hC; dm_addr = 32'h500; dm_wdata = 32'h55AA55AA;
        @(negedge clk); gnt_d = 1;
        @(negedge clk); gnt_d = 0; rst = 1;
        @(negedge clk); rst = 0; dm_req = 0; dm_we = 0; dm_be = 0; rvalid_d = 1; #1;
        tests++; if (m.req !== 1'b0 || m.we !== 1'b0 || m.be !== 4'h0 || m.addr !== 32'h0 || m.wdata !== 32'h0) begin fails++; $display("FAIL reset mid fields got req=%b we=%b be=%h addr=%h wdata=%h want all 0", m.req, m.we, m.be, m.addr, m.wdata); end
        tests++; if (dm_valid !== 1'b0 || if_valid !== 1'b0) begin fails++; $display("FAIL reset mid late rvalid dm/if got %b/%b want 0/0", dm_valid, if_valid); end
        @(negedge clk); rvalid_d = 0; #1;
        tests++; if (m.req !== 1'b0 || stall_M !== 1'b0) begin fails++; $display("FAIL reset mid idle req/stall_M got %b/%b want 0/0", m.req, stall_M); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_priority();
        test_killed_fetch();
        test_flush_rsp();
        test_backpressure();
        test_flush_idle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
